reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 20 ++
 rtl/reorder_buffer.sv | 231 +++++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer: default depth and the
// instruction-class encodings carried on issue_type.
package reorder_buffer_pkg;

  // log2 of the number of reorder-buffer entries
  localparam int ROB_WIDTH_BIT_DEF = 3;

  // Instruction classes tracked by the reorder buffer
  typedef enum logic [1:0] {
    ROB_TYPE_REG    = 2'd0,
    ROB_TYPE_STORE  = 2'd1,
    ROB_TYPE_BRANCH = 2'd2
  } rob_type_e;

  // Sequential fetch address after an instruction (wraps modulo 2^32)
  function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular queue of in-flight instructions. Entries are
// allocated in order at the tail, completed out of order by writeback and
// retired in order from the head. A mispredicted branch at the head flushes
// the whole buffer and reports the corrected fetch address.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  // issue
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [1:0]               issue_type,
  input  logic [4:0]               issue_rd,
  input  logic [31:0]              issue_pc,
  input  logic                     issue_pred_jump,
  output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
  // writeback
  input  logic                     wb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] wb_rob_id,
  input  logic [31:0]              wb_val,
  input  logic                     wb_jump,
  // register file
  output logic [4:0]               set_reg_id,
  output logic [31:0]              set_val,
  output logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id,
  output logic [4:0]               set_dep_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] set_dep_rob_id,
  // operand lookup
  input  logic [ROB_WIDTH_BIT-1:0] get_rob_id1,
  output logic                     rob_value1_ready,
  output logic [31:0]              rob_value1,
  input  logic [ROB_WIDTH_BIT-1:0] get_rob_id2,
  output logic                     rob_value2_ready,
  output logic [31:0]              rob_value2,
  // control
  output logic                     rob_clear,
  output logic [31:0]              clear_pc,
  output logic                     store_commit,
  output logic [ROB_WIDTH_BIT-1:0] store_commit_rob_id
);

  localparam int ROB_DEPTH = 1 << ROB_WIDTH_BIT;
  localparam logic [ROB_WIDTH_BIT:0] ROB_FULL = ROB_DEPTH[ROB_WIDTH_BIT:0];

  // Advance a head/tail pointer; the pointer width makes it wrap for free
  function automatic logic [ROB_WIDTH_BIT-1:0] ptr_inc(input logic [ROB_WIDTH_BIT-1:0] p);
    return p + ROB_WIDTH_BIT'(1);
  endfunction

  // Pointers and occupancy
  logic [ROB_WIDTH_BIT-1:0] head_r;
  logic [ROB_WIDTH_BIT-1:0] tail_r;
  logic [ROB_WIDTH_BIT:0]   count_r;

  // Per-entry control bits (reset) and payload (not reset)
  logic [ROB_DEPTH-1:0]     busy_r;
  logic [ROB_DEPTH-1:0]     ready_r;
  logic [1:0]               type_r [ROB_DEPTH];
  logic [4:0]               rd_r   [ROB_DEPTH];
  logic [31:0]              pc_r   [ROB_DEPTH];
  logic                     pred_r [ROB_DEPTH];
  logic [31:0]              val_r  [ROB_DEPTH];
  logic                     jump_r [ROB_DEPTH];

  // Cycle-level decisions
  logic commit_s;
  logic mispredict_s;
  logic issue_ready_s;
  logic issue_fire_s;
  logic wb_fire_s;
  logic fwd1_s;
  logic fwd2_s;

  // Head retirement decision. Everything is gated by reset so a reset in the
  // middle of a stream never leaks a commit or flush pulse.
  always_comb begin
    commit_s     = 1'b0;
    mispredict_s = 1'b0;
    if (rst_in && rdy_in && busy_r[head_r] && ready_r[head_r]) begin
      commit_s     = 1'b1;
      mispredict_s = (type_r[head_r] == ROB_TYPE_BRANCH) &&
                     (jump_r[head_r] != pred_r[head_r]);
    end else begin
      commit_s     = 1'b0;
      mispredict_s = 1'b0;
    end
  end

  // Issue/writeback acceptance. A full buffer does not see the slot freed by
  // a commit in the same cycle; a flush cycle accepts nothing new.
  always_comb begin
    issue_ready_s = rst_in && rdy_in && (count_r != ROB_FULL) && !mispredict_s;
    issue_fire_s  = issue_valid && issue_ready_s;
    wb_fire_s     = rst_in && rdy_in && !mispredict_s && wb_valid && busy_r[wb_rob_id];
    fwd1_s        = rst_in && wb_valid && (wb_rob_id == get_rob_id1);
    fwd2_s        = rst_in && wb_valid && (wb_rob_id == get_rob_id2);
  end

  // Issue-side outputs: readiness, allocated index and register dependency
  always_comb begin
    issue_ready    = issue_ready_s;
    issue_rob_id   = '0;
    set_dep_reg_id = 5'd0;
    set_dep_rob_id = '0;
    if (rst_in) begin
      issue_rob_id = tail_r;
    end else begin
      issue_rob_id = '0;
    end
    if (issue_fire_s && (issue_type == ROB_TYPE_REG)) begin
      set_dep_reg_id = issue_rd;
      set_dep_rob_id = tail_r;
    end else begin
      set_dep_reg_id = 5'd0;
      set_dep_rob_id = '0;
    end
  end

  // Retirement outputs: register write, store release, branch flush
  always_comb begin
    set_reg_id          = 5'd0;
    set_val             = 32'd0;
    set_reg_on_rob_id   = '0;
    store_commit        = 1'b0;
    store_commit_rob_id = '0;
    rob_clear           = 1'b0;
    clear_pc            = 32'd0;
    if (commit_s) begin
      case (type_r[head_r])
        ROB_TYPE_REG: begin
          set_reg_id        = rd_r[head_r];
          set_val           = val_r[head_r];
          set_reg_on_rob_id = head_r;
        end
        ROB_TYPE_STORE: begin
          store_commit        = 1'b1;
          store_commit_rob_id = head_r;
        end
        ROB_TYPE_BRANCH: begin
          rob_clear = mispredict_s;
          if (mispredict_s) begin
            clear_pc = jump_r[head_r] ? val_r[head_r] : fallthrough_pc(pc_r[head_r]);
          end else begin
            clear_pc = 32'd0;
          end
        end
        default: begin
          rob_clear = 1'b0;
        end
      endcase
    end else begin
      rob_clear = 1'b0;
    end
  end

  // Operand lookup with same-cycle writeback forwarding
  always_comb begin
    rob_value1_ready = ready_r[get_rob_id1] || fwd1_s;
    rob_value2_ready = ready_r[get_rob_id2] || fwd2_s;
    if (fwd1_s) begin
      rob_value1 = wb_val;
    end else begin
      rob_value1 = val_r[get_rob_id1];
    end
    if (fwd2_s) begin
      rob_value2 = wb_val;
    end else begin
      rob_value2 = val_r[get_rob_id2];
    end
  end

  // Pointer, occupancy and per-entry status update
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      busy_r  <= '0;
      ready_r <= '0;
    end else if (!rdy_in) begin
      head_r  <= head_r;
      tail_r  <= tail_r;
      count_r <= count_r;
    end else if (mispredict_s) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      busy_r  <= '0;
      ready_r <= '0;
    end else begin
      if (issue_fire_s) begin
        busy_r[tail_r]  <= 1'b1;
        ready_r[tail_r] <= 1'b0;
        tail_r          <= ptr_inc(tail_r);
      end
      if (wb_fire_s) begin
        ready_r[wb_rob_id] <= 1'b1;
      end
      // Retirement comes last so it wins over a late writeback to the head
      if (commit_s) begin
        busy_r[head_r]  <= 1'b0;
        ready_r[head_r] <= 1'b0;
        head_r          <= ptr_inc(head_r);
      end
      case ({issue_fire_s, commit_s})
        2'b10:   count_r <= count_r + {{ROB_WIDTH_BIT{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{ROB_WIDTH_BIT{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload capture on issue and writeback
  always_ff @(posedge clk_in) begin
    if (issue_fire_s) begin
      type_r[tail_r] <= issue_type;
      rd_r[tail_r]   <= issue_rd;
      pc_r[tail_r]   <= issue_pc;
      pred_r[tail_r] <= issue_pred_jump;
    end
    if (wb_fire_s) begin
      val_r[wb_rob_id]  <= wb_val;
      jump_r[wb_rob_id] <= wb_jump;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios plus randomized traffic,
// every cycle compared against an in-order queue model of the buffer.
module tb_reorder_buffer;

  localparam int W    = 3;
  localparam int SIZE = 1 << W;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          issue_valid;
  logic          issue_ready;
  logic [1:0]    issue_type;
  logic [4:0]    issue_rd;
  logic [31:0]   issue_pc;
  logic          issue_pred_jump;
  logic [W-1:0]  issue_rob_id;
  logic          wb_valid;
  logic [W-1:0]  wb_rob_id;
  logic [31:0]   wb_val;
  logic          wb_jump;
  logic [4:0]    set_reg_id;
  logic [31:0]   set_val;
  logic [W-1:0]  set_reg_on_rob_id;
  logic [4:0]    set_dep_reg_id;
  logic [W-1:0]  set_dep_rob_id;
  logic [W-1:0]  get_rob_id1;
  logic          rob_value1_ready;
  logic [31:0]   rob_value1;
  logic [W-1:0]  get_rob_id2;
  logic          rob_value2_ready;
  logic [31:0]   rob_value2;
  logic          rob_clear;
  logic [31:0]   clear_pc;
  logic          store_commit;
  logic [W-1:0]  store_commit_rob_id;

  reorder_buffer #(.ROB_WIDTH_BIT(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_type(issue_type),
    .issue_rd(issue_rd), .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump),
    .issue_rob_id(issue_rob_id),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_val(wb_val), .wb_jump(wb_jump),
    .set_reg_id(set_reg_id), .set_val(set_val), .set_reg_on_rob_id(set_reg_on_rob_id),
    .set_dep_reg_id(set_dep_reg_id), .set_dep_rob_id(set_dep_rob_id),
    .get_rob_id1(get_rob_id1), .rob_value1_ready(rob_value1_ready), .rob_value1(rob_value1),
    .get_rob_id2(get_rob_id2), .rob_value2_ready(rob_value2_ready), .rob_value2(rob_value2),
    .rob_clear(rob_clear), .clear_pc(clear_pc),
    .store_commit(store_commit), .store_commit_rob_id(store_commit_rob_id)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Compare one observed value against its expectation
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions in program order, oldest first
  typedef struct {
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic        done;
    logic [31:0] val;
    logic        jmp;
  } ent_t;

  ent_t q[$];
  int   hd = 0;

  // Decisions made for the current cycle, applied at the next edge
  bit m_commit, m_mis, m_issue, m_wb;
  int m_woff;

  function automatic int offset_of(input logic [W-1:0] id);
    return (int'(id) - hd + SIZE) % SIZE;
  endfunction

  // Expected lookup result for one port
  task automatic check_lookup(input string tag, input logic [W-1:0] id,
                              input logic got_rdy, input logic [31:0] got_val);
    int off;
    bit fwd, stored;
    off    = offset_of(id);
    fwd    = rst_in && wb_valid && (wb_rob_id == id);
    stored = (off < q.size()) && q[off].done;
    check({tag, "_ready"}, {31'd0, got_rdy}, {31'd0, fwd || stored});
    if (fwd) check({tag, "_fwd_val"}, got_val, wb_val);
    else if (stored) check({tag, "_val"}, got_val, q[off].val);
  endtask

  // Settle inputs, derive expected outputs from the model and compare
  task automatic settle();
    ent_t h;
    logic [W-1:0] tail_id;
    logic [31:0]  e_pc;
    #1;
    m_commit = rst_in && rdy_in && (q.size() > 0) && q[0].done;
    if (q.size() > 0) h = q[0];
    m_mis   = m_commit && (h.typ == 2'd2) && (h.jmp != h.pred);
    tail_id = W'((hd + q.size()) % SIZE);
    check("issue_ready", {31'd0, issue_ready},
          {31'd0, rst_in && rdy_in && (q.size() != SIZE) && !m_mis});
    m_issue = issue_valid && rst_in && rdy_in && (q.size() != SIZE) && !m_mis;
    check("issue_rob_id", {29'd0, issue_rob_id}, rst_in ? {29'd0, tail_id} : 32'd0);
    check("dep_reg", {27'd0, set_dep_reg_id},
          (m_issue && issue_type == 2'd0) ? {27'd0, issue_rd} : 32'd0);
    check("dep_rob", {29'd0, set_dep_rob_id},
          (m_issue && issue_type == 2'd0) ? {29'd0, tail_id} : 32'd0);
    check("set_reg_id", {27'd0, set_reg_id},
          (m_commit && h.typ == 2'd0) ? {27'd0, h.rd} : 32'd0);
    check("set_val", set_val, (m_commit && h.typ == 2'd0) ? h.val : 32'd0);
    check("set_reg_rob", {29'd0, set_reg_on_rob_id},
          (m_commit && h.typ == 2'd0) ? hd : 32'd0);
    check("store_commit", {31'd0, store_commit}, {31'd0, m_commit && h.typ == 2'd1});
    check("store_rob", {29'd0, store_commit_rob_id},
          (m_commit && h.typ == 2'd1) ? hd : 32'd0);
    check("rob_clear", {31'd0, rob_clear}, {31'd0, m_mis});
    e_pc = 32'd0;
    if (m_mis) e_pc = h.jmp ? h.val : h.pc + 32'd4;
    check("clear_pc", clear_pc, e_pc);
    check_lookup("lk1", get_rob_id1, rob_value1_ready, rob_value1);
    check_lookup("lk2", get_rob_id2, rob_value2_ready, rob_value2);
    m_woff = offset_of(wb_rob_id);
    m_wb   = rst_in && rdy_in && !m_mis && wb_valid && (m_woff < q.size());
  endtask

  // Clock edge: apply the cycle's decisions to the model, return at negedge
  task automatic advance();
    ent_t e;
    @(posedge clk_in);
    if (!rst_in) begin
      q.delete(); hd = 0;
    end else if (!rdy_in) begin
      hd = hd;
    end else if (m_mis) begin
      q.delete(); hd = 0;
    end else begin
      if (m_wb) begin
        e = q[m_woff]; e.done = 1'b1; e.val = wb_val; e.jmp = wb_jump; q[m_woff] = e;
      end
      if (m_commit) begin
        void'(q.pop_front()); hd = (hd + 1) % SIZE;
      end
      if (m_issue) begin
        e.typ = issue_type; e.rd = issue_rd; e.pc = issue_pc; e.pred = issue_pred_jump;
        e.done = 1'b0; e.val = 32'd0; e.jmp = 1'b0;
        q.push_back(e);
      end
    end
    @(negedge clk_in);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic idle();
    rst_in = 1'b1; rdy_in = 1'b1;
    issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0; issue_pc = 32'd0;
    issue_pred_jump = 1'b0;
    wb_valid = 1'b0; wb_rob_id = '0; wb_val = 32'd0; wb_jump = 1'b0;
    get_rob_id1 = '0; get_rob_id2 = '0;
  endtask

  task automatic do_reset();
    idle(); rst_in = 1'b0;
    step(); step();
    rst_in = 1'b1;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd,
                       input logic [31:0] pc, input logic pred);
    idle();
    issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_pc = pc; issue_pred_jump = pred;
    step();
  endtask

  task automatic wb(input logic [W-1:0] id, input logic [31:0] v, input logic j);
    idle();
    wb_valid = 1'b1; wb_rob_id = id; wb_val = v; wb_jump = j;
    step();
  endtask

  // Randomized cycle: wb_pct biases completion rate, rdy_pct/rst_pct stalls/resets
  task automatic rand_cycle(input int wb_pct, input int rdy_pct, input int rst_pct);
    rst_in          = ($urandom_range(0, 99) >= rst_pct);
    rdy_in          = ($urandom_range(0, 99) < rdy_pct);
    issue_valid     = ($urandom_range(0, 99) < 65);
    issue_type      = 2'($urandom_range(0, 2));
    issue_rd        = 5'($urandom_range(0, 31));
    issue_pc        = $urandom & 32'hFFFF_FFFC;
    issue_pred_jump = 1'($urandom_range(0, 1));
    wb_val          = $urandom;
    wb_jump         = 1'($urandom_range(0, 1));
    if (q.size() > 0 && $urandom_range(0, 99) < wb_pct) begin
      wb_valid  = 1'b1;
      wb_rob_id = W'((hd + $urandom_range(0, q.size() - 1)) % SIZE);
    end else begin
      wb_valid  = ($urandom_range(0, 99) < 5);
      wb_rob_id = W'($urandom_range(0, SIZE - 1));
    end
    get_rob_id1 = W'($urandom_range(0, SIZE - 1));
    get_rob_id2 = W'($urandom_range(0, SIZE - 1));
    step();
  endtask

  initial begin
    idle();
    rst_in = 1'b0;

    // Reset state
    do_reset();
    idle();
    settle();
    check("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    check("rst_rob_id", {29'd0, issue_rob_id}, 32'd0);
    advance();

    // Simple REG retirement
    idle(); issue_valid = 1'b1; issue_type = 2'd0; issue_rd = 5'd5; issue_pc = 32'h40;
    settle();
    check("dir_dep_reg", {27'd0, set_dep_reg_id}, 32'd5);
    check("dir_issue_id", {29'd0, issue_rob_id}, 32'd0);
    advance();
    wb(3'd0, 32'h1234, 1'b0);
    idle(); settle();
    check("dir_set_reg", {27'd0, set_reg_id}, 32'd5);
    check("dir_set_val", set_val, 32'h1234);
    check("dir_set_rob", {29'd0, set_reg_on_rob_id}, 32'd0);
    advance();

    // Fill to full, no bypass, then wrap
    do_reset();
    for (int i = 0; i < SIZE; i++) issue(2'd0, 5'(i + 1), 32'(i * 4), 1'b0);
    idle(); settle();
    check("dir_full", {31'd0, issue_ready}, 32'd0);
    advance();
    wb(3'd0, 32'h55, 1'b0);
    idle(); settle();
    check("dir_full_commit", {27'd0, set_reg_id}, 32'd1);
    check("dir_no_bypass", {31'd0, issue_ready}, 32'd0);
    advance();
    idle(); settle();
    check("dir_freed", {31'd0, issue_ready}, 32'd1);
    check("dir_wrap_id", {29'd0, issue_rob_id}, 32'd0);
    advance();

    // Mispredicted branches, taken and not taken
    do_reset();
    issue(2'd2, 5'd0, 32'h100, 1'b0);
    wb(3'd0, 32'h200, 1'b1);
    idle(); settle();
    check("dir_clear", {31'd0, rob_clear}, 32'd1);
    check("dir_clear_pc_t", clear_pc, 32'h200);
    advance();
    idle(); settle();
    check("dir_after_clear", {29'd0, issue_rob_id}, 32'd0);
    advance();
    issue(2'd2, 5'd0, 32'h100, 1'b1);
    wb(3'd0, 32'h300, 1'b0);
    idle(); settle();
    check("dir_clear_pc_nt", clear_pc, 32'h104);
    advance();

    // Lookup forwarding from a same-cycle writeback
    do_reset();
    wb(3'd1, 32'h77, 1'b0);
    for (int i = 0; i < 3; i++) issue(2'd0, 5'd3, 32'h0, 1'b0);
    idle(); wb_valid = 1'b1; wb_rob_id = 3'd2; wb_val = 32'hAB; get_rob_id1 = 3'd2;
    settle();
    check("dir_fwd_ready", {31'd0, rob_value1_ready}, 32'd1);
    check("dir_fwd_val", rob_value1, 32'hAB);
    advance();

    // Out-of-order completion, then reset with entries live, then stalls
    do_reset();
    for (int i = 0; i < 4; i++) issue(2'(i % 2), 5'(i + 8), 32'h0, 1'b0);
    wb(3'd1, 32'h11, 1'b0);
    step();
    wb(3'd0, 32'h10, 1'b0);
    step(); step();
    wb(3'd3, 32'h13, 1'b0);
    idle(); rst_in = 1'b0;
    settle();
    check("dir_rst_no_commit", {27'd0, set_reg_id}, 32'd0);
    check("dir_rst_no_store", {31'd0, store_commit}, 32'd0);
    advance();
    idle();
    for (int i = 0; i < 2; i++) issue(2'd0, 5'd9, 32'h0, 1'b0);
    wb(3'd0, 32'h99, 1'b0);
    idle(); rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    idle(); step(); step();

    // Randomized traffic in a few regimes
    for (int i = 0; i < 800; i++) rand_cycle(50, 95, 0);
    for (int i = 0; i < 600; i++) rand_cycle(8, 100, 0);
    for (int i = 0; i < 800; i++) rand_cycle(70, 80, 2);
    for (int i = 0; i < 600; i++) rand_cycle(30, 60, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
